dds_cmd_decoder: RTL and testbench

Consumes the SPI input stage's cmd_word/data_word/cmd_valid in the sys_clk domain and executes one command per SPI transaction. Maintains per-channel shadow and active DDS control registers (phase increment, phase offset, amplitude, waveform). Produces commit and phase-reset strobes for the downstream DDS cores and counts malformed commands.

---
 rtl/dds_cmd_decoder.sv | 188 ++++++++++++++++++
 tb/tb_dds_cmd_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dds_cmd_decoder.sv
// Executes one SPI command per cmd_valid high period: shadow/active DDS control
// registers per channel, commit and phase-reset strobes, rejected-command counter.
module dds_cmd_decoder #(
    parameter int DATA_WIDTH  = 16,
    parameter int PHASE_WIDTH = 32,
    parameter int NUM_CH      = 2
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic [7:0]                    cmd_word,
    input  logic [DATA_WIDTH-1:0]         data_word,
    input  logic                          cmd_valid,
    output logic [NUM_CH*PHASE_WIDTH-1:0] freq_inc,
    output logic [NUM_CH*16-1:0]          phase_off,
    output logic [NUM_CH*8-1:0]           ampl,
    output logic [NUM_CH*2-1:0]           wave_sel,
    output logic [NUM_CH-1:0]             update_strobe,
    output logic [NUM_CH-1:0]             phase_rst,
    output logic                          cmd_ack,
    output logic [7:0]                    err_count
);

    typedef enum logic [1:0] {IDLE, CAPTURE, EXEC, WAIT_LOW} state_e;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_FLO   = 4'h1;
    localparam logic [3:0] OP_FHI   = 4'h2;
    localparam logic [3:0] OP_PHASE = 4'h3;
    localparam logic [3:0] OP_AMPL  = 4'h4;
    localparam logic [3:0] OP_WAVE  = 4'h5;
    localparam logic [3:0] OP_UPD   = 4'h6;
    localparam logic [3:0] OP_PHRST = 4'h7;
    localparam logic [3:0] OP_SRST  = 4'hF;

    state_e state_q, state_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [NUM_CH-1:0][PHASE_WIDTH-1:0] sh_freq_q, sh_freq_d, act_freq_q, act_freq_d;
    logic [NUM_CH-1:0][15:0]            sh_phase_q, sh_phase_d, act_phase_q, act_phase_d;
    logic [NUM_CH-1:0][7:0]             sh_ampl_q, sh_ampl_d, act_ampl_q, act_ampl_d;
    logic [NUM_CH-1:0][1:0]             sh_wave_q, sh_wave_d, act_wave_q, act_wave_d;

    logic [NUM_CH-1:0] upd_q, upd_d, prst_q, prst_d;
    logic              ack_q, ack_d;
    logic [7:0]        err_q, err_d;

    logic [3:0]        opc;
    logic [2:0]        ch;
    logic [NUM_CH-1:0] mask;
    logic              ch_ok, bad;

    assign opc   = cmd_q[3:0];
    assign ch    = cmd_q[6:4];
    assign mask  = data_q[NUM_CH-1:0];
    assign ch_ok = ({1'b0, ch} < 4'(NUM_CH));
    // Channel range only matters for the shadow-write opcodes.
    assign bad   = cmd_q[7]
                 | ((opc >= 4'h8) && (opc != OP_SRST))
                 | ((opc >= OP_FLO) && (opc <= OP_WAVE) && !ch_ok);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (cmd_valid) state_d = CAPTURE;
            CAPTURE:  state_d = EXEC;
            EXEC:     state_d = WAIT_LOW;
            WAIT_LOW: if (!cmd_valid) state_d = IDLE;
            default:  state_d = WAIT_LOW;
        endcase
    end

    always_comb begin
        cmd_d       = cmd_q;
        data_d      = data_q;
        sh_freq_d   = sh_freq_q;
        sh_phase_d  = sh_phase_q;
        sh_ampl_d   = sh_ampl_q;
        sh_wave_d   = sh_wave_q;
        act_freq_d  = act_freq_q;
        act_phase_d = act_phase_q;
        act_ampl_d  = act_ampl_q;
        act_wave_d  = act_wave_q;
        upd_d       = '0;
        prst_d      = '0;
        ack_d       = 1'b0;
        err_d       = err_q;

        if (state_q == CAPTURE) begin
            cmd_d  = cmd_word;
            data_d = data_word;
        end

        if (state_q == EXEC) begin
            ack_d = 1'b1;
            if (bad) begin
                if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end else begin
                case (opc)
                    OP_FLO, OP_FHI, OP_PHASE, OP_AMPL, OP_WAVE: begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (ch == 3'(i)) begin
                                case (opc)
                                    OP_FLO:   sh_freq_d[i][15:0]             = data_q[15:0];
                                    OP_FHI:   sh_freq_d[i][PHASE_WIDTH-1:16] = data_q[15:0];
                                    OP_PHASE: sh_phase_d[i]                  = data_q[15:0];
                                    OP_AMPL:  sh_ampl_d[i]                   = data_q[7:0];
                                    default:  sh_wave_d[i]                   = data_q[1:0];
                                endcase
                            end
                        end
                    end
                    OP_UPD: begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (mask[i]) begin
                                act_freq_d[i]  = sh_freq_q[i];
                                act_phase_d[i] = sh_phase_q[i];
                                act_ampl_d[i]  = sh_ampl_q[i];
                                act_wave_d[i]  = sh_wave_q[i];
                            end
                        end
                        upd_d = mask;
                    end
                    OP_PHRST: prst_d = mask;
                    OP_SRST: begin
                        sh_freq_d   = '0;
                        sh_phase_d  = '0;
                        sh_ampl_d   = '1;
                        sh_wave_d   = '0;
                        act_freq_d  = '0;
                        act_phase_d = '0;
                        act_ampl_d  = '1;
                        act_wave_d  = '0;
                        prst_d      = '1;
                    end
                    default: ; // OP_NOP: ack only
                endcase
            end
        end
    end

    // Reset lands in WAIT_LOW so a cmd_valid level held through reset is ignored.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= WAIT_LOW;
            cmd_q       <= '0;
            data_q      <= '0;
            sh_freq_q   <= '0;
            sh_phase_q  <= '0;
            sh_ampl_q   <= '1;
            sh_wave_q   <= '0;
            act_freq_q  <= '0;
            act_phase_q <= '0;
            act_ampl_q  <= '1;
            act_wave_q  <= '0;
            upd_q       <= '0;
            prst_q      <= '0;
            ack_q       <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            sh_freq_q   <= sh_freq_d;
            sh_phase_q  <= sh_phase_d;
            sh_ampl_q   <= sh_ampl_d;
            sh_wave_q   <= sh_wave_d;
            act_freq_q  <= act_freq_d;
            act_phase_q <= act_phase_d;
            act_ampl_q  <= act_ampl_d;
            act_wave_q  <= act_wave_d;
            upd_q       <= upd_d;
            prst_q      <= prst_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    assign freq_inc      = act_freq_q;
    assign phase_off     = act_phase_q;
    assign ampl          = act_ampl_q;
    assign wave_sel      = act_wave_q;
    assign update_strobe = upd_q;
    assign phase_rst     = prst_q;
    assign cmd_ack       = ack_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_dds_cmd_decoder.sv
// Directed bench for dds_cmd_decoder (NUM_CH=2) with hand-computed expectations.
module tb_dds_cmd_decoder;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [7:0]  cmd_word;
    logic [15:0] data_word;
    logic        cmd_valid;
    logic [63:0] freq_inc;
    logic [31:0] phase_off;
    logic [15:0] ampl;
    logic [3:0]  wave_sel;
    logic [1:0]  update_strobe;
    logic [1:0]  phase_rst;
    logic        cmd_ack;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;

    logic [1:0] u, p;

    dds_cmd_decoder #(.DATA_WIDTH(16), .PHASE_WIDTH(32), .NUM_CH(2)) dut (
        .sys_clk(sys_clk), .rst(rst), .cmd_word(cmd_word), .data_word(data_word),
        .cmd_valid(cmd_valid), .freq_inc(freq_inc), .phase_off(phase_off), .ampl(ampl),
        .wave_sel(wave_sel), .update_strobe(update_strobe), .phase_rst(phase_rst),
        .cmd_ack(cmd_ack), .err_count(err_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction; checks the ack lands exactly 2 cycles after the
    // first sampling edge and lasts one cycle. Returns strobes seen with ack.
    task automatic send(input logic [7:0] c, input logic [15:0] d,
                        output logic [1:0] upd, output logic [1:0] prst);
        @(negedge sys_clk);
        cmd_word  = c;
        data_word = d;
        cmd_valid = 1'b1;
        @(posedge sys_clk);
        @(posedge sys_clk); #1;
        check("ack_early", {63'd0, cmd_ack}, 64'd0);
        check("strobe_early", {60'd0, update_strobe, phase_rst}, 64'd0);
        @(posedge sys_clk); #1;
        check("ack", {63'd0, cmd_ack}, 64'd1);
        upd  = update_strobe;
        prst = phase_rst;
        @(posedge sys_clk); #1;
        check("ack_len", {63'd0, cmd_ack}, 64'd0);
        check("strobe_len", {60'd0, update_strobe, phase_rst}, 64'd0);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_word = 8'h06; data_word = 16'h0003; cmd_valid = 1'b1;
        // 1: reset with cmd_valid held high; must not execute after release
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge sys_clk); #1;
            check("no_ack_after_rst", {63'd0, cmd_ack}, 64'd0);
        end
        check("rst_freq", freq_inc, 64'd0);
        check("rst_ampl", {48'd0, ampl}, 64'h0000_0000_0000_FFFF);
        check("rst_phase", {32'd0, phase_off}, 64'd0);
        check("rst_wave", {60'd0, wave_sel}, 64'd0);
        check("rst_err", {56'd0, err_count}, 64'd0);
        @(negedge sys_clk);
        cmd_valid = 1'b0;

        // 2: frequency assembly and commit on ch0; UPDATE ignores ch field
        send(8'h01, 16'h5678, u, p);
        send(8'h02, 16'h1234, u, p);
        check("freq_pre_upd", freq_inc, 64'd0);
        send(8'h76, 16'h0001, u, p);
        check("upd_strobe_01", {62'd0, u}, 64'd1);
        check("freq_ch0", freq_inc, 64'h0000_0000_1234_5678);
        check("upd_ch_ignored_err", {56'd0, err_count}, 64'd0);

        // 3: shadow ampl not visible until UPDATE
        send(8'h14, 16'h0080, u, p);
        check("ampl_shadow_only", {48'd0, ampl}, 64'h0000_0000_0000_FFFF);
        send(8'h06, 16'h0003, u, p);
        check("upd_strobe_11", {62'd0, u}, 64'd3);
        check("ampl_ch1", {48'd0, ampl}, 64'h0000_0000_0000_80FF);
        check("freq_after_upd11", freq_inc, 64'h0000_0000_1234_5678);

        send(8'h03, 16'hABCD, u, p);
        send(8'h15, 16'h0002, u, p);
        send(8'h06, 16'h0001, u, p);
        check("phase_ch0", {32'd0, phase_off}, 64'h0000_0000_0000_ABCD);
        check("wave_ch1_uncommitted", {60'd0, wave_sel}, 64'd0);
        send(8'h06, 16'h0002, u, p);
        check("wave_ch1", {60'd0, wave_sel}, 64'h8);
        send(8'h06, 16'h0000, u, p);
        check("upd_mask0", {62'd0, u}, 64'd0);

        // cmd_valid dropping during CAPTURE still executes
        @(negedge sys_clk);
        cmd_word = 8'h00; data_word = 16'h0000; cmd_valid = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        @(posedge sys_clk);
        @(posedge sys_clk); #1;
        check("ack_valid_dropped", {63'd0, cmd_ack}, 64'd1);
        repeat (2) @(posedge sys_clk);

        // 4: rejected commands and saturation
        send(8'h09, 16'h0000, u, p);
        check("err_opcode", {56'd0, err_count}, 64'd1);
        send(8'h34, 16'h0011, u, p);
        check("err_channel", {56'd0, err_count}, 64'd2);
        send(8'h81, 16'h1111, u, p);
        check("err_reserved", {56'd0, err_count}, 64'd3);
        check("err_no_ampl_change", {48'd0, ampl}, 64'h0000_0000_0000_80FF);
        send(8'h06, 16'h0003, u, p);
        check("err_no_shadow_change", {48'd0, ampl}, 64'h0000_0000_0000_80FF);
        check("err_no_freq_change", freq_inc, 64'h0000_0000_1234_5678);
        for (int i = 0; i < 300; i++) send(8'h0A, 16'h0000, u, p);
        check("err_saturate", {56'd0, err_count}, 64'd255);

        // 5: phase reset and soft reset
        send(8'h07, 16'h0002, u, p);
        check("phrst_10", {62'd0, p}, 64'd2);
        check("phrst_no_upd", {62'd0, u}, 64'd0);
        send(8'h0F, 16'h0000, u, p);
        check("srst_phrst", {62'd0, p}, 64'd3);
        check("srst_freq", freq_inc, 64'd0);
        check("srst_ampl", {48'd0, ampl}, 64'h0000_0000_0000_FFFF);
        check("srst_phase", {32'd0, phase_off}, 64'd0);
        check("srst_wave", {60'd0, wave_sel}, 64'd0);
        check("srst_err_kept", {56'd0, err_count}, 64'd255);
        send(8'h06, 16'h0003, u, p);
        check("srst_shadow_freq", freq_inc, 64'd0);

        // 6: rst during EXEC of an UPDATE aborts it
        send(8'h04, 16'h0011, u, p);
        @(negedge sys_clk);
        cmd_word = 8'h06; data_word = 16'h0001; cmd_valid = 1'b1;
        @(posedge sys_clk);
        @(posedge sys_clk);
        @(negedge sys_clk);
        rst = 1'b1;
        @(posedge sys_clk); #1;
        check("abort_ack", {63'd0, cmd_ack}, 64'd0);
        check("abort_upd", {62'd0, update_strobe}, 64'd0);
        check("abort_ampl", {48'd0, ampl}, 64'h0000_0000_0000_FFFF);
        check("abort_err", {56'd0, err_count}, 64'd0);
        @(negedge sys_clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge sys_clk); #1;
            check("abort_wait_low", {63'd0, cmd_ack}, 64'd0);
        end
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        send(8'h06, 16'h0001, u, p);
        check("post_abort_upd", {62'd0, u}, 64'd1);
        check("post_abort_ampl", {48'd0, ampl}, 64'h0000_0000_0000_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
